// File: rtl/pulse_qual_pkg.sv
// Shared definitions for the multi-channel pulse qualifier: FSM state
// encodings and their width.
package pulse_qual_pkg;

  localparam int ST_W = 3;

  localparam logic [ST_W-1:0] ST_IDLE    = 3'b000;
  localparam logic [ST_W-1:0] ST_ARM     = 3'b100;
  localparam logic [ST_W-1:0] ST_QUAL    = 3'b101;
  localparam logic [ST_W-1:0] ST_FIRE    = 3'b001;
  localparam logic [ST_W-1:0] ST_HOLD    = 3'b011;
  localparam logic [ST_W-1:0] ST_RELEASE = 3'b111;
  localparam logic [ST_W-1:0] ST_DONE    = 3'b110;

endpackage

// File: rtl/pulse_qual_chan.sv
// One pulse-qualifier channel. It synchronises the raw pin, applies the
// polarity, qualifies the pulse width, emits a one-cycle event, enforces a
// hold-off and then waits for release. It also keeps an event counter and a
// sticky stuck-active flag.
module pulse_qual_chan
  import pulse_qual_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int EVT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ce_i,
  input  logic             gpio_i,
  input  logic             pol_i,
  input  logic [CNT_W-1:0] thr_i,
  input  logic [CNT_W-1:0] wait_i,
  input  logic [CNT_W-1:0] max_i,
  input  logic             clear_i,
  output logic             new_count_o,
  output logic             err_stuck_o,
  output logic [EVT_W-1:0] event_count_o,
  output logic [ST_W-1:0]  state_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [EVT_W-1:0] EVT_ONE = {{(EVT_W-1){1'b0}}, 1'b1};

  // Counter increment that sticks at all-ones, so an all-ones threshold
  // can never be exceeded and a long stuck pulse never wraps.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : (v + CNT_ONE);
  endfunction

  logic             sync1_q, sync2_q;
  logic             s;
  logic [ST_W-1:0]  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] thr_q, thr_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0] max_q, max_d;
  logic [EVT_W-1:0] evt_q;
  logic             err_q;
  logic             stuck_set;

  // Two-flop synchroniser for the asynchronous pin; deliberately not gated by ce.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= gpio_i;
      sync2_q <= sync1_q;
    end
  end

  // Polarity is applied live, after the synchroniser.
  assign s = sync2_q ^ pol_i;

  // Next-state, counter and config-latch logic of the qualifier FSM.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    thr_d     = thr_q;
    wait_d    = wait_q;
    max_d     = max_q;
    stuck_set = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        thr_d   = thr_i;
        wait_d  = wait_i;
        max_d   = max_i;
        cnt_d   = '0;
        state_d = ST_ARM;
      end
      ST_ARM: begin
        if (s) begin
          cnt_d   = '0;
          state_d = ST_QUAL;
        end
      end
      ST_QUAL: begin
        if (cnt_q > thr_q) begin
          state_d = ST_FIRE;
        end else if (!s) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      ST_FIRE: begin
        cnt_d   = '0;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        cnt_d = sat_inc(cnt_q);
        if (cnt_q > wait_q) begin
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!s) begin
          state_d = ST_DONE;
        end else begin
          cnt_d     = sat_inc(cnt_q);
          stuck_set = (max_q != '0) && (cnt_q > max_q);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state, timing counter and latched config advance only on enabled cycles.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      thr_q   <= '0;
      wait_q  <= '0;
      max_q   <= '0;
    end else if (ce_i) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      thr_q   <= thr_d;
      wait_q  <= wait_d;
      max_q   <= max_d;
    end
  end

  // Event counter: counts on leaving FIRE; a coincident clear leaves exactly one.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      evt_q <= '0;
    end else if (ce_i && (state_q == ST_FIRE)) begin
      evt_q <= clear_i ? EVT_ONE : (evt_q + EVT_ONE);
    end else if (clear_i) begin
      evt_q <= '0;
    end
  end

  // Sticky stuck-active flag: a new detection beats a coincident clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if (ce_i && stuck_set) begin
      err_q <= 1'b1;
    end else if (clear_i) begin
      err_q <= 1'b0;
    end
  end

  assign new_count_o   = (state_q == ST_FIRE);
  assign err_stuck_o   = err_q;
  assign event_count_o = evt_q;
  assign state_o       = state_q;

endmodule

// File: rtl/pulse_qual_mc.sv
// N-channel pulse qualifier between the GPIO pins and the timestamp logic.
// The shared configuration is fanned out to independent channels, and their
// outputs are packed into flat buses.
module pulse_qual_mc
  import pulse_qual_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int CNT_W = 32,
  parameter int EVT_W = 16
) (
  input  logic                  clk,
  input  logic                  hard_rst,
  input  logic                  ce,
  input  logic [N_CH-1:0]       gpio,
  input  logic [N_CH-1:0]       polarity,
  input  logic [CNT_W-1:0]      threshold,
  input  logic [CNT_W-1:0]      waiting,
  input  logic [CNT_W-1:0]      max_width,
  input  logic                  clear,
  output logic [N_CH-1:0]       new_count,
  output logic [N_CH-1:0]       err_stuck,
  output logic [N_CH*EVT_W-1:0] event_count,
  output logic [N_CH*ST_W-1:0]  state
);

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    pulse_qual_chan #(
      .CNT_W(CNT_W),
      .EVT_W(EVT_W)
    ) u_chan (
      .clk_i        (clk),
      .rst_i        (hard_rst),
      .ce_i         (ce),
      .gpio_i       (gpio[k]),
      .pol_i        (polarity[k]),
      .thr_i        (threshold),
      .wait_i       (waiting),
      .max_i        (max_width),
      .clear_i      (clear),
      .new_count_o  (new_count[k]),
      .err_stuck_o  (err_stuck[k]),
      .event_count_o(event_count[k*EVT_W +: EVT_W]),
      .state_o      (state[k*ST_W +: ST_W])
    );
  end

endmodule
